// File: rtl/relogio_pkg.sv
// relogio_pkg: shared types and constants for the clock adjust sequencer.
package relogio_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    HORAS    = 2'b01,
    MINUTOS  = 2'b10,
    SEGUNDOS = 2'b11
  } modo_ajuste_t;

  localparam int MS_PER_S = 1000;

  // Next state of the NORMAL -> HORAS -> MINUTOS -> SEGUNDOS -> NORMAL ring.
  function automatic modo_ajuste_t next_modo(input modo_ajuste_t m);
    case (m)
      NORMAL:  return HORAS;
      HORAS:   return MINUTOS;
      MINUTOS: return SEGUNDOS;
      default: return NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/relogio_tick_gen.sv
// relogio_tick_gen: free-running millisecond tick, one clock wide.
// The tick is registered, so the first tick appears one ms after reset
// is released (every cycle from the second one when the divider is 1).
module relogio_tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic ms_tick
);

  localparam int DIV   = (CLK_FREQ_HZ / 1000 > 0) ? (CLK_FREQ_HZ / 1000) : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divide the clock down to 1 kHz; the tick fires when the divider wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      ms_tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      ms_tick <= 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
      ms_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/relogio_ajuste_ctrl.sv
// relogio_ajuste_ctrl: adjust-mode sequencer for the clock.
// Steps NORMAL -> HORAS -> MINUTOS -> SEGUNDOS on btn_mode, issues
// single-cycle inc/dec pulses with auto-repeat, and drives the blink gate
// for the field being edited.
// Optional: define RELOGIO_AJUSTE_TIMEOUT_EN to fall back to NORMAL after
// TIMEOUT_S seconds without button activity in an adjust mode.
module relogio_ajuste_ctrl
  import relogio_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 100_000_000,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100,
  parameter int BLINK_HALF_MS    = 250,
  parameter int TIMEOUT_S        = 10
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [1:0] modo_ajuste,
  output logic       ajuste_inc,
  output logic       ajuste_dec,
  output logic       run_en,
  output logic       blink_on
);

  localparam int HOLD_LIM = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS
                                                                  : REPEAT_PERIOD_MS;
  localparam int HOLD_W  = $clog2(HOLD_LIM + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_MS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_DELAY  = HOLD_W'(REPEAT_DELAY_MS);
  localparam logic [HOLD_W-1:0]  HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD_MS);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_HALF_MS - 1);

  // Every timing parameter is a count of ticks and must be at least one.
  if (REPEAT_DELAY_MS < 1 || REPEAT_PERIOD_MS < 1 || BLINK_HALF_MS < 1 || TIMEOUT_S < 1)
  begin : g_param_check
    $error("relogio_ajuste_ctrl: timing parameters must be >= 1");
  end

  logic ms_tick;

  relogio_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick_gen (
    .clk     (clk_100MHz),
    .reset   (reset),
    .ms_tick (ms_tick)
  );

  // A button only counts once it has been seen released after reset, so a
  // button held through reset stays inert until it is pressed again.
  logic arm_mode, arm_inc, arm_dec;
  logic prev_mode, prev_inc, prev_dec;
  logic lvl_mode, lvl_inc, lvl_dec;
  logic rise_mode, rise_inc, rise_dec;

  assign lvl_mode  = btn_mode & arm_mode;
  assign lvl_inc   = btn_inc  & arm_inc;
  assign lvl_dec   = btn_dec  & arm_dec;
  assign rise_mode = lvl_mode & ~prev_mode;
  assign rise_inc  = lvl_inc  & ~prev_inc;
  assign rise_dec  = lvl_dec  & ~prev_dec;

  // Button history: arming flags and previous qualified levels.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      arm_mode  <= 1'b0;
      arm_inc   <= 1'b0;
      arm_dec   <= 1'b0;
      prev_mode <= 1'b0;
      prev_inc  <= 1'b0;
      prev_dec  <= 1'b0;
    end else begin
      arm_mode  <= arm_mode | ~btn_mode;
      arm_inc   <= arm_inc  | ~btn_inc;
      arm_dec   <= arm_dec  | ~btn_dec;
      prev_mode <= lvl_mode;
      prev_inc  <= lvl_inc;
      prev_dec  <= lvl_dec;
    end
  end

  modo_ajuste_t modo_q;
  logic         in_adjust;
  logic         timeout_fire;

  assign in_adjust   = (modo_q != NORMAL);
  assign modo_ajuste = modo_q;

  // Press pulses: a mode edge in the same cycle wins, and simultaneous
  // inc+dec cancels both.
  logic edge_inc, edge_dec;
  assign edge_inc = in_adjust & ~rise_mode & rise_inc & ~lvl_dec;
  assign edge_dec = in_adjust & ~rise_mode & rise_dec & ~lvl_inc;

  // Auto-repeat runs only while exactly one of inc/dec is held. A fresh
  // press restarts the count so the first repeat lands a full delay later.
  logic              one_held, hold_clr, rep_fire, repeating;
  logic [HOLD_W-1:0] hold_cnt, hold_next;

  assign one_held  = in_adjust & ~rise_mode & (lvl_inc ^ lvl_dec);
  assign hold_clr  = ~one_held | rise_inc | rise_dec;
  assign hold_next = hold_cnt + 1'b1;
  assign rep_fire  = ~hold_clr & ms_tick &
                     (hold_next == (repeating ? HOLD_PERIOD : HOLD_DELAY));

  logic pulse_inc_n, pulse_dec_n;
  assign pulse_inc_n = edge_inc | (rep_fire & lvl_inc);
  assign pulse_dec_n = edge_dec | (rep_fire & lvl_dec);

  // Hold counter: initial delay first, then the repeat period.
  always_ff @(posedge clk_100MHz) begin
    if (reset || hold_clr) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (ms_tick) begin
      if (rep_fire) begin
        hold_cnt  <= '0;
        repeating <= 1'b1;
      end else begin
        hold_cnt  <= hold_next;
      end
    end
  end

`ifdef RELOGIO_AJUSTE_TIMEOUT_EN
  localparam int SEC_W = $clog2(TIMEOUT_S + 1);
  localparam int MS_W  = $clog2(MS_PER_S + 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_PER_S - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TIMEOUT_S - 1);

  logic [MS_W-1:0]  idle_ms;
  logic [SEC_W-1:0] idle_s;
  logic             idle_clr;

  // Any button edge or issued pulse counts as activity, which also lets a
  // coincident edge cancel the timeout.
  assign idle_clr     = ~in_adjust | rise_mode | rise_inc | rise_dec |
                        pulse_inc_n | pulse_dec_n;
  assign timeout_fire = ~idle_clr & ms_tick & (idle_ms == MS_LAST) & (idle_s == SEC_LAST);

  // Inactivity timer in ms and whole seconds while in an adjust mode.
  always_ff @(posedge clk_100MHz) begin
    if (reset || idle_clr || timeout_fire) begin
      idle_ms <= '0;
      idle_s  <= '0;
    end else if (ms_tick) begin
      if (idle_ms == MS_LAST) begin
        idle_ms <= '0;
        idle_s  <= idle_s + 1'b1;
      end else begin
        idle_ms <= idle_ms + 1'b1;
      end
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // Mode FSM; run_en is registered alongside the mode it reflects.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      modo_q <= NORMAL;
      run_en <= 1'b1;
    end else if (rise_mode) begin
      modo_q <= next_modo(modo_q);
      run_en <= (next_modo(modo_q) == NORMAL);
    end else if (timeout_fire) begin
      modo_q <= NORMAL;
      run_en <= 1'b1;
    end
  end

  // Registered single-cycle inc/dec pulses to the time counters.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      ajuste_inc <= 1'b0;
      ajuste_dec <= 1'b0;
    end else begin
      ajuste_inc <= pulse_inc_n;
      ajuste_dec <= pulse_dec_n;
    end
  end

  logic [BLINK_W-1:0] blink_ph;

  // Blink gate: solid in NORMAL, restarted visible on mode change or edit.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      blink_on <= 1'b1;
      blink_ph <= '0;
    end else if (!in_adjust || rise_mode || pulse_inc_n || pulse_dec_n || timeout_fire) begin
      blink_on <= 1'b1;
      blink_ph <= '0;
    end else if (ms_tick) begin
      if (blink_ph == BLINK_LAST) begin
        blink_ph <= '0;
        blink_on <= ~blink_on;
      end else begin
        blink_ph <= blink_ph + 1'b1;
      end
    end
  end

endmodule
